// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader.
//   HDR_DEFAULT     : header byte emitted ahead of register data
//   state_e         : dump sequencer states
//   bytes_per_word  : bytes per register word (DWIDTH/8)
//   cnt_width       : width of a byte counter that can hold 0..nb-1
package regfile_dump_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned dwidth);
        return dwidth / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_ser.sv
// Word serializer: loads a DWIDTH word plus a remaining-byte count and
// shifts it out LSB first as bytes with a valid/ready handshake.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   load             : capture load_word/load_cnt and raise out_valid
//   load_word        : word to send (only the low (load_cnt+1) bytes go out)
//   load_cnt         : number of bytes to send minus one
//   out_data         : current byte (bits [7:0] of the shift register)
//   out_valid        : out_data valid
//   out_ready        : sink accepts on out_valid && out_ready
//   last_accept      : final byte of the loaded word accepted this cycle
module regfile_dump_ser
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    localparam int unsigned NB = bytes_per_word(DWIDTH),
    localparam int unsigned CW = cnt_width(NB)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_word,
    input  logic [CW-1:0]     load_cnt,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last_accept
);

    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              accept;

    assign accept      = valid_q && out_ready;
    assign last_accept = accept && (cnt_q == '0);
    assign out_data    = shift_q[7:0];
    assign out_valid   = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = load_word;
            cnt_d   = load_cnt;
            valid_d = 1'b1;
        end else if (accept) begin
            shift_d = shift_q >> 8;
            if (cnt_q == '0) begin
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Debug reader for the CPU register file. A start pulse in IDLE walks all
// 1<<AWIDTH registers through the read port and streams HDR followed by
// each register LSB first over a valid/ready byte interface. busy/hold stay
// high for the whole dump so the core freezes register writes.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : dump request, sampled only in IDLE
//   busy, hold   : dump in progress (identical)
//   rsel         : register file read select
//   rdata        : read data for rsel, valid by the next posedge
//   out_data     : stream byte
//   out_valid    : out_data valid
//   out_ready    : sink ready
//   done         : one-cycle pulse after the final byte is accepted
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned DWIDTH = 16,
    parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              hold,
    output logic [AWIDTH-1:0] rsel,
    input  logic [DWIDTH-1:0] rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam int unsigned NB = bytes_per_word(DWIDTH);
    localparam int unsigned CW = cnt_width(NB);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] index_q, index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ser_load;
    logic [DWIDTH-1:0] ser_word;
    logic [CW-1:0]     ser_cnt;
    logic              ser_last;

    // The header is pushed through the serializer as a one-byte word, so
    // out_data/out_valid always come straight from its registers.
    regfile_dump_ser #(
        .DWIDTH (DWIDTH)
    ) u_ser (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (ser_load),
        .load_word   (ser_word),
        .load_cnt    (ser_cnt),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .last_accept (ser_last)
    );

    // rsel tracks the index register, which only advances when the last
    // byte of a register is accepted, so it is stable from LOAD through SEND.
    assign rsel = index_q;
    assign busy = busy_q;
    assign hold = busy_q;
    assign done = done_q;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        ser_load = 1'b0;
        ser_word = '0;
        ser_cnt  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_HEAD;
                    index_d  = '0;
                    ser_load = 1'b1;
                    ser_word = DWIDTH'(HDR);
                    ser_cnt  = '0;
                end
            end
            ST_HEAD: begin
                if (ser_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                ser_word = rdata;
                ser_cnt  = CW'(NB - 1);
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_last) begin
                    if (index_q == '1) begin
                        state_d = ST_FIN;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a 16x16 instance and an 8x8 instance run side by
// side on shared start/ready/reset. Expected streams are queued when a dump
// is issued; a negedge monitor pops and compares on every handshake.
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, out_ready;

    logic        busy0, hold0, ov0, done0;
    logic [3:0]  rsel0;
    logic [15:0] rdata0;
    logic [7:0]  od0;

    logic        busy1, hold1, ov1, done1;
    logic [2:0]  rsel1;
    logic [7:0]  rdata1;
    logic [7:0]  od1;

    logic [15:0] regs0[16];
    logic [7:0]  regs1[8];

    assign rdata0 = regs0[rsel0];
    assign rdata1 = regs1[rsel1];

    regfile_dump #(.AWIDTH(4), .DWIDTH(16), .HDR(8'hA5)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy0), .hold(hold0),
        .rsel(rsel0), .rdata(rdata0), .out_data(od0), .out_valid(ov0),
        .out_ready(out_ready), .done(done0)
    );

    regfile_dump #(.AWIDTH(3), .DWIDTH(8), .HDR(8'hA5)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy1), .hold(hold1),
        .rsel(rsel1), .rdata(rdata1), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .done(done1)
    );

    typedef struct {
        logic [7:0] data;
        int         reg_idx;     // -1 for the header
        bit         last_group;  // last byte of header / register
        bit         last_stream;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_cnt[2];
    bit   rnd_ready = 1'b0;

    function automatic void check(input bit ok, input string name,
                                  input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Sink readiness: always ready, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference stream: header, then every register LSB byte first.
    task automatic push_streams();
        exp_t e;
        q0.push_back('{8'hA5, -1, 1'b1, 1'b0});
        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 2; b++) begin
                e.data        = 8'(regs0[r] >> (8 * b));
                e.reg_idx     = r;
                e.last_group  = (b == 1);
                e.last_stream = (b == 1) && (r == 15);
                q0.push_back(e);
            end
        end
        q1.push_back('{8'hA5, -1, 1'b1, 1'b0});
        for (int r = 0; r < 8; r++) begin
            q1.push_back('{regs1[r], r, 1'b1, r == 7});
        end
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
    endtask

    bit         pv[2], pr[2], dexp[2], adone[2];
    logic [7:0] pd[2];
    int         bub[2], nxt[2];

    task automatic mon_step(input int id, input bit v, input bit r, input logic [7:0] d,
                            input bit dn, input bit bs, input bit hd, input int rs,
                            input bit rn);
        exp_t e;
        bit   have, dnew;
        if (!rn) begin
            pv[id] = 0; pr[id] = 0; bub[id] = 0; dexp[id] = 0; adone[id] = 0;
            return;
        end
        check(hd == bs, $sformatf("hold_eq_busy%0d", id), hd, bs);
        check(dn == dexp[id], $sformatf("done_pulse%0d", id), dn, dexp[id]);
        if (adone[id]) check(bs == 1'b0, $sformatf("busy_after_done%0d", id), bs, 0);
        if (pv[id] && !pr[id]) begin
            check(v == 1'b1, $sformatf("valid_held%0d", id), v, 1);
            check(d == pd[id], $sformatf("data_stable%0d", id), d, pd[id]);
        end
        if (bub[id] == 1) begin
            check(v == 1'b0, $sformatf("load_bubble%0d", id), v, 0);
            check(rs == nxt[id], $sformatf("rsel_load%0d", id), rs, nxt[id]);
            bub[id] = 2;
        end else if (bub[id] == 2) begin
            check(v == 1'b1, $sformatf("resume_after_bubble%0d", id), v, 1);
            bub[id] = 0;
        end
        dnew = 1'b0;
        if (v && r) begin
            have = 1'b0;
            if (id == 0) begin
                if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            end else begin
                if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
                check(1'b0, $sformatf("extra_byte%0d", id), d, 0);
            end else begin
                acc_cnt[id]++;
                check(d == e.data, $sformatf("stream_byte%0d", id), d, e.data);
                if (e.reg_idx >= 0)
                    check(rs == e.reg_idx, $sformatf("rsel_send%0d", id), rs, e.reg_idx);
                if (e.last_stream) begin
                    dnew = 1'b1;
                end else if (e.last_group) begin
                    bub[id] = 1;
                    nxt[id] = e.reg_idx + 1;
                end
            end
        end
        adone[id] = dexp[id];
        dexp[id]  = dnew;
        pv[id] = v;
        pr[id] = r;
        pd[id] = d;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, ov0, out_ready, od0, done0, busy0, hold0, int'(rsel0), reset_n);
            mon_step(1, ov1, out_ready, od1, done1, busy1, hold1, int'(rsel1), reset_n);
        end
    end

    task automatic issue_start();
        push_streams();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(busy0 == 1'b1, "busy_after_start0", busy0, 1);
        check(busy1 == 1'b1, "busy_after_start1", busy1, 1);
        check(ov0 == 1'b1 && od0 == 8'hA5, "header_first0", od0, 8'hA5);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((busy0 || busy1 || q0.size() != 0 || q1.size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(c < budget, "dump_timeout", c, budget);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c = 0;
        while (acc_cnt[0] < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(c < budget, "byte_wait_timeout", c, budget);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 16; i++) regs0[i] = 16'($urandom);
        for (int i = 0; i < 8; i++)  regs1[i] = 8'($urandom);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs0[i] = 16'h1100 + 16'(i);
        for (int i = 0; i < 8; i++)  regs1[i] = 8'hF0 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        check(ov0 == 0 && busy0 == 0 && hold0 == 0 && done0 == 0, "reset_ctrl0", ov0, 0);
        check(rsel0 == 0 && od0 == 0, "reset_data0", {rsel0, od0}, 0);
        check(ov1 == 0 && busy1 == 0 && rsel1 == 0 && od1 == 0, "reset_all1", ov1, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known pattern, sink always ready.
        rnd_ready = 1'b0;
        issue_start();
        wait_idle(500);
        check(acc_cnt[0] == 33, "byte_count0", acc_cnt[0], 33);
        check(acc_cnt[1] == 9, "byte_count1", acc_cnt[1], 9);

        // Same pattern then random contents, with a stalling sink.
        rnd_ready = 1'b1;
        for (int run = 0; run < 3; run++) begin
            if (run > 0) randomize_regs();
            issue_start();
            wait_idle(3000);
            check(acc_cnt[0] == 33, "byte_count_rnd0", acc_cnt[0], 33);
            check(acc_cnt[1] == 9, "byte_count_rnd1", acc_cnt[1], 9);
        end

        // A second start mid-dump must not restart or queue a new dump.
        randomize_regs();
        issue_start();
        wait_bytes(5, 3000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(3000);
        repeat (20) @(posedge clk);
        #1;
        check(acc_cnt[0] == 33, "single_stream0", acc_cnt[0], 33);
        check(busy0 == 1'b0, "idle_after_ignored_start", busy0, 0);

        // Reset mid-dump abandons the stream; a fresh start gives a full one.
        rnd_ready = 1'b0;
        randomize_regs();
        issue_start();
        wait_bytes(10, 500);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check(ov0 == 0 && busy0 == 0 && hold0 == 0, "abort_reset0", {ov0, busy0, hold0}, 0);
        check(ov1 == 0 && busy1 == 0 && hold1 == 0, "abort_reset1", {ov1, busy1, hold1}, 0);
        @(posedge clk);
        #1;
        issue_start();
        wait_idle(500);
        check(acc_cnt[0] == 33, "post_reset_count0", acc_cnt[0], 33);
        check(acc_cnt[1] == 9, "post_reset_count1", acc_cnt[1], 9);

        check(q0.size() == 0 && q1.size() == 0, "queues_drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
